// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer.
// Picks a hole from the running game counter, keeps the mole lit for an up
// window, scores hits, charges a life on each miss and waits a gap before
// the next spawn. All window timing advances only on the tick enable.
// Optional feature macro: MOLE_SPEEDUP_EN shortens the up window by one
// tick per 8 points scored, with a floor of 2 ticks.
// state_dbg exposes the FSM state (0 IDLE, 1 SPAWN, 2 UP, 3 GAP, 4 OVER).
module mole_scheduler #(
  parameter int UP_TICKS   = 8,
  parameter int GAP_TICKS  = 4,
  parameter int LIVES_INIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [3:0]  count,
  input  logic [15:0] hit,
  output logic [15:0] mole,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_UP    = 3'd2,
    S_GAP   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] UP_W    = 8'(UP_TICKS);
  localparam logic [7:0] GAP_W   = 8'(GAP_TICKS);
  localparam logic [1:0] LIVES_W = 2'(LIVES_INIT);

  state_t      state;
  logic [7:0]  timer;
  logic [3:0]  idx;
  logic        first;     // set until the first spawn of a game is done
  logic [3:0]  next_idx;
  logic [7:0]  up_window;
  logic        hit_now;
  logic        expire;

  assign state_dbg = state;

`ifdef MOLE_SPEEDUP_EN
  logic [4:0] slow;
  assign slow = score[7:3];

  // Up window shrinks by one tick per 8 points, never below 2 ticks.
  always_comb begin
    up_window = 8'd2;
    if (UP_W >= ({3'b000, slow} + 8'd2))
      up_window = UP_W - {3'b000, slow};
  end
`else
  assign up_window = UP_W;
`endif

  // Never respawn in the hole just used, except on the first spawn of a game.
  assign next_idx = (!first && (count == idx)) ? count + 4'd1 : count;
  assign hit_now  = hit[idx];
  assign expire   = tick && (timer == 8'd1);

  // Game FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mole      <= 16'd0;
      score     <= 8'd0;
      lives     <= 2'd0;
      game_over <= 1'b0;
      busy      <= 1'b0;
      timer     <= 8'd0;
      idx       <= 4'd0;
      first     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          mole <= 16'd0;
          if (start) begin
            score     <= 8'd0;
            lives     <= LIVES_W;
            idx       <= 4'd0;
            first     <= 1'b1;
            game_over <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          idx   <= next_idx;
          first <= 1'b0;
          timer <= up_window;
          state <= S_UP;
        end
        S_UP: begin
          if (hit_now) begin
            // A hit wins over a simultaneous window expiry.
            if (score != 8'hFF)
              score <= score + 8'd1;
            mole  <= 16'd0;
            timer <= GAP_W;
            state <= S_GAP;
          end else if (expire) begin
            lives <= lives - 2'd1;
            mole  <= 16'd0;
            if (lives == 2'd1) begin
              timer     <= 8'd0;
              game_over <= 1'b1;
              busy      <= 1'b0;
              state     <= S_OVER;
            end else begin
              timer <= GAP_W;
              state <= S_GAP;
            end
          end else begin
            mole <= 16'd1 << idx;
            if (tick)
              timer <= timer - 8'd1;
          end
        end
        S_GAP: begin
          mole <= 16'd0;
          if (tick) begin
            if (timer == 8'd1)
              state <= S_SPAWN;
            else
              timer <= timer - 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed game sequences for mole_scheduler.
// Expected mole patterns are pushed into exp_q when the spawn count is
// driven and popped when the mole lights; score/lives come from a model.
module tb_mole_scheduler;

  localparam int UP_T    = 8;
  localparam int GAP_T   = 4;
  localparam int LIVES_T = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        start;
  logic [3:0]  count;
  logic [15:0] hit;
  logic [15:0] mole;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        game_over;
  logic        busy;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  m_idx;
  logic        m_first;
  logic [7:0]  exp_score;
  logic [1:0]  exp_lives;

  mole_scheduler #(
    .UP_TICKS(UP_T),
    .GAP_TICKS(GAP_T),
    .LIVES_INIT(LIVES_T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .start(start),
    .count(count),
    .hit(hit),
    .mole(mole),
    .score(score),
    .lives(lives),
    .game_over(game_over),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  function automatic int exp_window(input logic [7:0] s);
`ifdef MOLE_SPEEDUP_EN
    int sl;
    sl = int'(s >> 3);
    return (UP_T >= sl + 2) ? UP_T - sl : 2;
`else
    return UP_T;
`endif
  endfunction

  // drive the count the next spawn will see and predict the hole
  task automatic arm_spawn(input logic [3:0] c);
    count = c;
    if (!m_first && (c == m_idx))
      m_idx = c + 4'd1;
    else
      m_idx = c;
    m_first = 1'b0;
    exp_q.push_back(16'd1 << m_idx);
  endtask

  task automatic wait_mole();
    int n;
    n = 0;
    while (mole == 16'd0 && n < 20) begin
      cyc();
      n++;
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty got=%h want=none", mole);
    end else begin
      chk("sb_mole", mole, exp_q.pop_front());
    end
  endtask

  task automatic hit_round();
    wait_mole();
    hit = 16'd1 << m_idx;
    cyc();
    hit = 16'd0;
    if (exp_score != 8'hFF)
      exp_score = exp_score + 8'd1;
    chk("hit_score", 16'(score), 16'(exp_score));
    chk("hit_clr", mole, 16'd0);
    arm_spawn(4'($urandom_range(0, 15)));
    repeat (GAP_T) do_tick();
  endtask

  task automatic miss_round(input int exp_ticks);
    int n;
    logic [1:0] l0;
    wait_mole();
    l0 = lives;
    n = 0;
    while (lives == l0 && n < 300) begin
      do_tick();
      n++;
    end
    chk("window", 16'(n), 16'(exp_ticks));
    exp_lives = exp_lives - 2'd1;
    chk("miss_lives", 16'(lives), 16'(exp_lives));
    chk("miss_clr", mole, 16'd0);
    chk("miss_score", 16'(score), 16'(exp_score));
    if (exp_lives == 2'd0) begin
      chk("over_go", 16'(game_over), 16'd1);
      chk("over_busy", 16'(busy), 16'd0);
      chk("over_state", 16'(state_dbg), 16'd4);
    end else begin
      arm_spawn(4'($urandom_range(0, 15)));
      repeat (GAP_T) do_tick();
    end
  endtask

  // directed sequence
  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b1; count = 4'd0; hit = 16'hFFFF;
    m_first = 1'b0; m_idx = 4'd0; exp_score = 8'd0; exp_lives = 2'd0;
    repeat (2) cyc();
    start = 1'b0; hit = 16'd0;
    chk("rst_mole", mole, 16'd0);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_lives", 16'(lives), 16'd0);
    chk("rst_go", 16'(game_over), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    cyc();
    chk("idle_state", 16'(state_dbg), 16'd0);

    // game 1: spawn latency, stray hits, a hit, gap and no-repeat hole
    m_first = 1'b1; m_idx = 4'd0;
    arm_spawn(4'd5);
    exp_score = 8'd0; exp_lives = 2'(LIVES_T);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("e0_busy", 16'(busy), 16'd1);
    chk("e0_mole", mole, 16'd0);
    cyc();
    chk("e1_mole", mole, 16'd0);
    cyc();
    chk("e2_mole", mole, exp_q.pop_front());
    chk("e2_lives", 16'(lives), 16'd3);
    chk("e2_score", 16'(score), 16'd0);
    chk("e2_busy", 16'(busy), 16'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_start_mole", mole, 16'h0020);
    chk("busy_start_state", 16'(state_dbg), 16'd2);
    hit = ~16'h0020;
    cyc();
    hit = 16'd0;
    chk("stray_mole", mole, 16'h0020);
    chk("stray_score", 16'(score), 16'd0);
    chk("stray_lives", 16'(lives), 16'd3);
    hit = 16'h0020;
    cyc();
    hit = 16'd0;
    exp_score = 8'd1;
    chk("hit5_mole", mole, 16'd0);
    chk("hit5_score", 16'(score), 16'(exp_score));
    hit = 16'hFFFF;
    cyc();
    hit = 16'd0;
    chk("gap_hit_score", 16'(score), 16'(exp_score));
    arm_spawn(4'd5);
    repeat (GAP_T - 1) do_tick();
    chk("gap_hold", 16'(state_dbg), 16'd3);
    do_tick();
    chk("spawn_up", 16'(state_dbg), 16'd2);
    chk("spawn_dark", mole, 16'd0);
    repeat (LIVES_T) miss_round(UP_T);
    hit = 16'hFFFF;
    repeat (3) do_tick();
    hit = 16'd0;
    chk("hold_score", 16'(score), 16'(exp_score));
    chk("hold_lives", 16'(lives), 16'd0);
    chk("hold_go", 16'(game_over), 16'd1);

    // game 2: restart from OVER, hit on the expiring tick, reset in UP
    m_first = 1'b1;
    arm_spawn(4'd9);
    exp_score = 8'd0; exp_lives = 2'(LIVES_T);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rs_go", 16'(game_over), 16'd0);
    chk("rs_score", 16'(score), 16'd0);
    chk("rs_lives", 16'(lives), 16'd3);
    chk("rs_busy", 16'(busy), 16'd1);
    wait_mole();
    repeat (UP_T - 1) do_tick();
    chk("pre_expire", mole, 16'd1 << m_idx);
    tick = 1'b1;
    hit = 16'd1 << m_idx;
    cyc();
    tick = 1'b0;
    hit = 16'd0;
    exp_score = 8'd1;
    chk("tie_score", 16'(score), 16'(exp_score));
    chk("tie_lives", 16'(lives), 16'd3);
    chk("tie_mole", mole, 16'd0);
    arm_spawn(4'($urandom_range(0, 15)));
    repeat (GAP_T) do_tick();
    repeat (6) hit_round();
    wait_mole();
    chk("pre_rst_score", 16'(score), 16'd7);
    reset = 1'b1; start = 1'b1; hit = 16'd1 << m_idx;
    cyc();
    reset = 1'b0; start = 1'b0; hit = 16'd0;
    chk("mrst_state", 16'(state_dbg), 16'd0);
    chk("mrst_mole", mole, 16'd0);
    chk("mrst_score", 16'(score), 16'd0);
    chk("mrst_lives", 16'(lives), 16'd0);
    chk("mrst_go", 16'(game_over), 16'd0);
    chk("mrst_busy", 16'(busy), 16'd0);

    // game 3: long run for window length and score saturation
    m_first = 1'b1;
    arm_spawn(4'($urandom_range(0, 15)));
    exp_score = 8'd0; exp_lives = 2'(LIVES_T);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (16) hit_round();
    miss_round(exp_window(exp_score));
    while (exp_score != 8'hFF) hit_round();
    miss_round(exp_window(exp_score));
    hit_round();
    miss_round(exp_window(exp_score));
    chk("sb_drain", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
